quad_sqrt: RTL and testbench

- Iterative magnitude stage directly downstream of the sum-of-squares block.
- Takes the unsigned Q5.24 sum c = a^2 + b^2 and returns floor(sqrt(c)) as unsigned Q3.12, i.e. the vector magnitude of (a, b).
- Restoring digit-by-digit algorithm: one result bit per clock.
- Valid/ready handshake on both sides, so it can sit behind the pipelined squarer and in front of any consumer.

---
 rtl/quad_pkg.sv | 17 +
 rtl/quad_sqrt_if.sv | 22 ++
 rtl/quad_sqrt_step.sv | 26 ++
 rtl/quad_sqrt.sv | 117 +++++++++++
 tb/tb_quad_sqrt.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/quad_pkg.sv
// Shared widths, state encoding and data types for the magnitude (sqrt) stage.
package quad_pkg;

  localparam int IN_W    = 29;  // Q5.24 radicand
  localparam int OUT_W   = 15;  // Q3.12 root
  localparam int REM_W   = 16;  // partial remainder, bounded by 2*root
  localparam int FRAC_W  = 12;  // full fractional width of the root
  localparam int SHIFT_W = 2 * OUT_W;
  localparam int CNT_W   = 4;
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_t;

  typedef logic unsigned [IN_W-1:0]  quad_sum_t;
  typedef logic unsigned [OUT_W-1:0] quad_mag_t;

endpackage

// File: rtl/quad_sqrt_if.sv
// Valid/ready request and response bundle between squarer, sqrt stage and consumer.
interface quad_sqrt_if;
  import quad_pkg::*;

  logic      in_valid;
  logic      in_ready;
  quad_sum_t in_c;
  logic      out_valid;
  logic      out_ready;
  quad_mag_t out_r;
  logic      out_exact;

  modport slave (
    input  in_valid, in_c, out_ready,
    output in_ready, out_valid, out_r, out_exact
  );

  modport master (
    output in_valid, in_c, out_ready,
    input  in_ready, out_valid, out_r, out_exact
  );
endinterface

// File: rtl/quad_sqrt_step.sv
// One restoring-sqrt iteration: brings down two radicand bits, emits one root bit.
// Purely combinational; no latency, no backpressure.
module sqrt_step
  import quad_pkg::*;
(
  input  logic [REM_W-1:0] rem,
  input  quad_mag_t        root,
  input  logic [1:0]       digit,
  output logic [REM_W-1:0] rem_next,
  output quad_mag_t        root_next
);

  // Compared one bit wider than strictly needed so every input bit is consumed.
  logic [REM_W+1:0] rem_n;
  logic [REM_W+1:0] trial;
  logic             ge;

  always_comb begin
    rem_n     = {rem, digit};
    trial     = {1'b0, root, 2'b01};
    ge        = (rem_n >= trial);
    rem_next  = ge ? REM_W'(rem_n - trial) : REM_W'(rem_n);
    root_next = OUT_W'({root, ge});
  end

endmodule

// File: rtl/quad_sqrt.sv
// Iterative floor(sqrt) of a Q5.24 sum of squares, producing a Q3.12 magnitude.
// Result 15 cycles after accept; one job in flight, result held until out_ready.
module quad_sqrt
  import quad_pkg::*;
#(
  parameter int FWL_R = 12
) (
  input  logic      clk,
  input  logic      rstn,
  quad_sqrt_if.slave io
);

  sqrt_state_t             state_q, state_d;
  logic [SHIFT_W-1:0]      shift_q, shift_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  quad_mag_t               root_q, root_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  quad_mag_t               out_r_q, out_r_d;
  logic                    out_exact_q, out_exact_d;

  logic [REM_W-1:0]        step_rem;
  quad_mag_t               step_root;
  quad_mag_t               step_root_m;

  sqrt_step u_step (
    .rem       (rem_q),
    .root      (root_q),
    .digit     (shift_q[SHIFT_W-1 -: 2]),
    .rem_next  (step_rem),
    .root_next (step_root)
  );

  generate
    if (FWL_R < FRAC_W) begin : g_trunc
      localparam quad_mag_t KEEP = quad_mag_t'({OUT_W{1'b1}} << (FRAC_W - FWL_R));
      assign step_root_m = step_root & KEEP;
    end else begin : g_full
      assign step_root_m = step_root;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    out_r_d     = out_r_q;
    out_exact_d = out_exact_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          shift_d = {1'b0, io.in_c};
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = ITER_LAST;
          state_d = CALC;
        end
      end
      CALC: begin
        shift_d = {shift_q[SHIFT_W-3:0], 2'b00};
        rem_d   = step_rem;
        root_d  = step_root;
        if (cnt_q == '0) begin
          // Exactness uses the untruncated remainder, independent of FWL_R.
          out_r_d     = step_root_m;
          out_exact_d = (step_rem == '0);
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_exact_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_exact_q <= out_exact_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_r     = out_r_q;
  assign io.out_exact = out_exact_q;

endmodule

// File: tb/tb_quad_sqrt.sv
// Directed bench for quad_sqrt: full-width (FWL_R=12) and truncated (FWL_R=8) instances in lockstep.
module tb_quad_sqrt;
  import quad_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  quad_sqrt_if io12 ();
  quad_sqrt_if io8 ();

  assign io8.in_valid  = io12.in_valid;
  assign io8.in_c      = io12.in_c;
  assign io8.out_ready = io12.out_ready;

  quad_sqrt #(.FWL_R(12)) dut12 (.clk(clk), .rstn(rstn), .io(io12.slave));
  quad_sqrt #(.FWL_R(8))  dut8  (.clk(clk), .rstn(rstn), .io(io8.slave));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Wait for in_ready, present c for exactly one accept edge, then scramble in_c.
  task automatic accept(input string tag, input logic [28:0] c, input logic rdy);
    bit to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (io12.in_ready) begin
        to = 1'b0;
        break;
      end
    end
    chk({tag, "_in_ready_wait"}, 32'(to), 0);
    io12.in_valid  = 1'b1;
    io12.in_c      = c;
    io12.out_ready = rdy;
    @(posedge clk);
    #1;
    io12.in_valid = 1'b0;
    io12.in_c     = 29'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int lat = 0;
    bit to  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (io12.out_valid) begin
        to = 1'b0;
        break;
      end
    end
    chk({tag, "_valid_wait"}, 32'(to), 0);
    chk({tag, "_latency"}, lat, 15);
  endtask

  task automatic finish(input string tag, input logic [14:0] exp_r, input logic exp_x);
    @(negedge clk);
    chk({tag, "_out_r"}, io12.out_r, exp_r);
    chk({tag, "_exact"}, io12.out_exact, exp_x);
    chk({tag, "_out_r_fwl8"}, io8.out_r, exp_r & 15'h7FF0);
    chk({tag, "_valid_fwl8"}, io8.out_valid, 1);
    io12.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io12.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, io12.out_valid, 0);
    chk({tag, "_in_ready_back"}, io12.in_ready, 1);
  endtask

  task automatic do_op(input string tag, input logic [28:0] c, input logic [14:0] exp_r,
                       input logic exp_x, input logic rdy);
    accept(tag, c, rdy);
    wait_valid(tag);
    finish(tag, exp_r, exp_x);
  endtask

  initial begin
    bit stale;
    io12.in_valid  = 1'b0;
    io12.in_c      = '0;
    io12.out_ready = 1'b0;

    #1;
    chk("rst_in_ready", io12.in_ready, 0);
    chk("rst_out_valid", io12.out_valid, 0);
    chk("rst_out_r", io12.out_r, 0);
    chk("rst_exact", io12.out_exact, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_in_ready_pre_edge", io12.in_ready, 0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_first_edge", io12.in_ready, 1);

    do_op("zero",  29'd0,          15'd0,     1'b1, 1'b0);
    do_op("unity", 29'd16777216,   15'd4096,  1'b1, 1'b1);
    do_op("full",  29'd536870911,  15'd23170, 1'b0, 1'b0);
    do_op("three_four", 29'd419430400, 15'd20480, 1'b1, 1'b0);
    do_op("two",   29'd2,          15'd1,     1'b0, 1'b0);
    do_op("nine9", 29'd99,         15'd9,     1'b0, 1'b1);

    // Backpressure: result must hold and a stray in_valid must be dropped.
    accept("bp", 29'd419430400, 1'b0);
    wait_valid("bp");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_out_r", io12.out_r, 20480);
      chk("bp_hold_valid", io12.out_valid, 1);
      chk("bp_hold_in_ready", io12.in_ready, 0);
      if (k == 3) begin
        io12.in_valid = 1'b1;
        io12.in_c     = 29'd4;
      end else begin
        io12.in_valid = 1'b0;
      end
    end
    io12.in_valid = 1'b0;
    finish("bp", 15'd20480, 1'b1);
    @(negedge clk);
    chk("bp_no_phantom_accept", io12.in_ready, 1);
    do_op("four", 29'd4, 15'd2, 1'b1, 1'b0);

    // Asynchronous reset seven cycles into CALC, between edges.
    accept("rst_mid", 29'd536870911, 1'b0);
    repeat (7) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_mid_in_ready", io12.in_ready, 0);
    chk("rst_mid_out_valid", io12.out_valid, 0);
    chk("rst_mid_out_r", io12.out_r, 0);
    chk("rst_mid_exact", io12.out_exact, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_in_ready_back", io12.in_ready, 1);
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io12.out_valid || io8.out_valid) stale = 1'b1;
    end
    chk("rst_mid_no_stale_valid", 32'(stale), 0);
    do_op("post_rst_unity", 29'd16777216, 15'd4096, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
